// File: rtl/band_energy_accum.sv
// band_energy_accum: harmonic band energy, sum of Re^2 + Im^2 over bins am..bm.
// Fixed point is 32-bit sign-magnitude (Q15.16). Sign bits of the bins are ignored.
// Bins are read through a one-cycle-latency RAM port.
// Optional macro SATURATE_EN: square overflow or accumulator carry clamps the
// result to 0x7FFFFFFF and sets a sticky ovf flag. Without it the result wraps
// modulo 2^31 and ovf is tied to 0.
module band_energy_accum #(
    parameter int N      = 32,
    parameter int Q      = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startacc,
    input  logic [ADDR_W-1:0] am,
    input  logic [ADDR_W-1:0] bm,
    output logic [ADDR_W-1:0] sw_addr,
    output logic              sw_rd,
    input  logic [N-1:0]      sw_re,
    input  logic [N-1:0]      sw_im,
    output logic [N-1:0]      energy,
    output logic              doneacc,
    output logic              ovf
);

    localparam int M  = N - 1;   // magnitude width
    localparam int P  = 2 * M;   // full product width
    localparam int SW = M + 2;   // three-term sum width

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CHECK, S_FETCH, S_WAIT, S_SQUARE, S_ACCUM, S_DONE
    } state_t;

    state_t            state_q, state_d;
    // k is one bit wider than a bin index so bm = all-ones terminates cleanly
    logic [ADDR_W:0]   k_q, k_d;
    logic [ADDR_W-1:0] bm_q, bm_d;
    logic [M-1:0]      acc_q, acc_d;
    logic [M-1:0]      sq_re_q, sq_re_d;
    logic [M-1:0]      sq_im_q, sq_im_d;
    logic [ADDR_W-1:0] sw_addr_q, sw_addr_d;
    logic              sw_rd_q, sw_rd_d;
    logic [N-1:0]      energy_q, energy_d;
    logic              done_q, done_d;

    logic [M-1:0]      mag_re, mag_im;
    logic [P-1:0]      prod_re, prod_im;
    logic [SW-1:0]     sum;

    assign mag_re  = M'(sw_re);
    assign mag_im  = M'(sw_im);
    assign prod_re = P'(mag_re) * P'(mag_re);
    assign prod_im = P'(mag_im) * P'(mag_im);
    assign sum     = SW'(acc_q) + SW'(sq_re_q) + SW'(sq_im_q);

`ifdef SATURATE_EN
    logic sq_ovf_q, sq_ovf_d;
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign sw_addr = sw_addr_q;
    assign sw_rd   = sw_rd_q;
    assign energy  = energy_q;
    assign doneacc = done_q;

    // Next-state and datapath updates; every register holds unless its state acts
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        bm_d      = bm_q;
        acc_d     = acc_q;
        sq_re_d   = sq_re_q;
        sq_im_d   = sq_im_q;
        sw_addr_d = sw_addr_q;
        sw_rd_d   = sw_rd_q;
        energy_d  = energy_q;
        done_d    = done_q;
`ifdef SATURATE_EN
        sq_ovf_d  = sq_ovf_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (startacc) state_d = S_INIT;
            end
            S_INIT: begin
                acc_d   = '0;
                k_d     = {1'b0, am};
                bm_d    = bm;
`ifdef SATURATE_EN
                ovf_d   = 1'b0;
`endif
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (k_q <= {1'b0, bm_q}) state_d = S_FETCH;
                else                     state_d = S_DONE;
            end
            S_FETCH: begin
                sw_addr_d = k_q[ADDR_W-1:0];
                sw_rd_d   = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                sw_rd_d = 1'b0;
                state_d = S_SQUARE;
            end
            S_SQUARE: begin
                sq_re_d  = M'(prod_re >> Q);
                sq_im_d  = M'(prod_im >> Q);
`ifdef SATURATE_EN
                sq_ovf_d = (|(prod_re >> (Q + M))) | (|(prod_im >> (Q + M)));
`endif
                state_d  = S_ACCUM;
            end
            S_ACCUM: begin
`ifdef SATURATE_EN
                // Once clamped, the band stays clamped
                if (ovf_q || sq_ovf_q || (|(sum >> M))) begin
                    acc_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = M'(sum);
                end
`else
                acc_d   = M'(sum);
`endif
                k_d     = k_q + 1'b1;
                state_d = S_CHECK;
            end
            S_DONE: begin
                energy_d = {1'b0, acc_q};
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any run in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            bm_q      <= '0;
            acc_q     <= '0;
            sq_re_q   <= '0;
            sq_im_q   <= '0;
            sw_addr_q <= '0;
            sw_rd_q   <= 1'b0;
            energy_q  <= '0;
            done_q    <= 1'b0;
`ifdef SATURATE_EN
            sq_ovf_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            bm_q      <= bm_d;
            acc_q     <= acc_d;
            sq_re_q   <= sq_re_d;
            sq_im_q   <= sq_im_d;
            sw_addr_q <= sw_addr_d;
            sw_rd_q   <= sw_rd_d;
            energy_q  <= energy_d;
            done_q    <= done_d;
`ifdef SATURATE_EN
            sq_ovf_q  <= sq_ovf_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_band_energy_accum.sv
// Bench for band_energy_accum: directed bands with hand-computed energies.
// Expected results (energy, ovf, completion cycle) and expected read addresses
// are queued by the driver; monitors pop them on doneacc and sw_rd.
module tb_band_energy_accum;

    localparam int N      = 32;
    localparam int ADDR_W = 8;
    localparam int W      = 65;   // {ovf, energy[31:0], done_cycle[31:0]}

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              startacc = 1'b0;
    logic [ADDR_W-1:0] am = '0;
    logic [ADDR_W-1:0] bm = '0;
    logic [ADDR_W-1:0] sw_addr;
    logic              sw_rd;
    logic [N-1:0]      sw_re = '0;
    logic [N-1:0]      sw_im = '0;
    logic [N-1:0]      energy;
    logic              doneacc;
    logic              ovf;

    band_energy_accum #(.N(N), .Q(16), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .startacc(startacc), .am(am), .bm(bm),
        .sw_addr(sw_addr), .sw_rd(sw_rd), .sw_re(sw_re), .sw_im(sw_im),
        .energy(energy), .doneacc(doneacc), .ovf(ovf)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- spectrum RAM model (one-cycle read latency) ----------------
    logic [N-1:0] mem_re [0:255];
    logic [N-1:0] mem_im [0:255];

    always @(posedge clk) begin
        if (sw_rd) begin
            sw_re <= mem_re[sw_addr];
            sw_im <= mem_im[sw_addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0]      exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                checks = 0;
    int                errors = 0;
    logic              chk_addr = 1'b1;
    logic [N-1:0]      last_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor: one expected entry per doneacc pulse
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst && doneacc) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: doneacc=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                check("energy", 64'(energy), 64'(e[63:32]));
                check("ovf", 64'(ovf), 64'(e[64]));
                check("done_cycle", 64'(cyc), 64'(e[31:0]));
            end
        end
    end

    // Read monitor: one expected address per sw_rd cycle
    always @(negedge clk) begin
        if (rst && sw_rd && chk_addr) begin
            if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: sw_rd=1 addr=%0d at cycle %0d, expected no read", sw_addr, cyc);
            end else begin
                check("sw_addr", 64'(sw_addr), 64'(addr_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results pending after %0d cycles, expected 0", exp_q.size(), budget);
            exp_q.delete();
        end
        @(negedge clk);
        check("addr_drain", 64'(addr_q.size()), 64'd0);
        addr_q.delete();
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input logic [31:0] e_en, input logic e_ovf, input int lat);
        @(negedge clk);
        check("energy_hold", 64'(energy), 64'(last_exp));
        am       = a;
        bm       = b;
        startacc = 1'b1;
        exp_q.push_back({e_ovf, e_en, 32'(cyc + 1 + lat)});
        for (int i = int'(a); i <= int'(b); i++) addr_q.push_back(8'(i));
        @(negedge clk);
        startacc = 1'b0;
        @(negedge clk);
        // Band limits are latched by now; later changes must not matter
        am = 8'($urandom_range(0, 255));
        bm = 8'($urandom_range(0, 255));
        wait_drain(200);
        last_exp = e_en;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        int pulses;
        for (int i = 0; i < 256; i++) begin
            mem_re[i] = '0;
            mem_im[i] = '0;
        end

        repeat (2) @(negedge clk);
        check("rst_energy", 64'(energy), 64'd0);
        check("rst_doneacc", 64'(doneacc), 64'd0);
        check("rst_sw_rd", 64'(sw_rd), 64'd0);
        check("rst_sw_addr", 64'(sw_addr), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single bin: 2^2 + 1^2 = 5.0
        mem_re[3] = 32'h0002_0000;
        mem_im[3] = 32'h0001_0000;
        run(8'd3, 8'd3, 32'h0005_0000, 1'b0, 8);

        // Three bins of 1.0 and -1.0: 3 * 2.0 = 6.0
        for (int i = 2; i <= 4; i++) begin
            mem_re[i] = 32'h0001_0000;
            mem_im[i] = 32'h8001_0000;
        end
        run(8'd2, 8'd4, 32'h0006_0000, 1'b0, 18);

        // Empty band
        run(8'd10, 8'd9, 32'h0000_0000, 1'b0, 3);

        // 200.0^2 exceeds the 31-bit magnitude
        mem_re[0] = 32'h00C8_0000;
        mem_im[0] = 32'h0000_0000;
`ifdef SATURATE_EN
        run(8'd0, 8'd0, 32'h7FFF_FFFF, 1'b1, 8);
`else
        run(8'd0, 8'd0, 32'h1C40_0000, 1'b0, 8);
`endif

        // Reset in the middle of a long band
        @(negedge clk);
        chk_addr = 1'b0;
        am       = 8'd0;
        bm       = 8'd7;
        startacc = 1'b1;
        @(negedge clk);
        startacc = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_energy", 64'(energy), 64'd0);
        check("midrst_doneacc", 64'(doneacc), 64'd0);
        check("midrst_sw_rd", 64'(sw_rd), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("post_rst_energy", 64'(energy), 64'd0);
        chk_addr = 1'b1;
        last_exp = '0;

        mem_re[1] = 32'h0001_0000;
        mem_im[1] = 32'h0000_0000;
        run(8'd1, 8'd1, 32'h0001_0000, 1'b0, 8);

        // startacc held high: back-to-back runs every 9 cycles
        mem_re[5] = 32'h0000_8000;
        mem_im[5] = 32'h0000_8000;
        @(negedge clk);
        check("energy_hold", 64'(energy), 64'(last_exp));
        am       = 8'd5;
        bm       = 8'd5;
        startacc = 1'b1;
        base     = cyc + 1;
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back({1'b0, 32'h0000_8000, 32'(base + 8 + 9 * r)});
            addr_q.push_back(8'd5);
        end
        n      = 0;
        pulses = 0;
        while (pulses < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (doneacc) pulses++;
        end
        startacc = 1'b0;
        wait_drain(50);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
